uart_tx_queue: RTL and testbench

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_tx_queue_pkg.sv | 15 +
 rtl/uart_tx_fifo.sv | 67 ++++++
 rtl/uart_tx_queue.sv | 128 ++++++++++++
 tb/tb_uart_tx_queue.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_queue_pkg.sv
// Shared defaults and serializer state encoding for the UART
// transmit queue.
package uart_tx_queue_pkg;

    localparam int SERIAL_WCNT_DEF = 100;
    localparam int QADDR_DEF       = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the serializer: storage, wrapping pointers,
// occupancy count and the sticky overflow flag.
module uart_tx_fifo
    import uart_tx_queue_pkg::*;
#(
    parameter int QADDR = QADDR_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] wdata,
    input  logic       we,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       ready,
    output logic       empty,
    output logic       ovf
);

    localparam int DEPTH = 1 << QADDR;

    logic [7:0]       mem [DEPTH];
    logic [QADDR-1:0] wptr;
    logic [QADDR-1:0] rptr;
    logic [QADDR:0]   count;
    logic             push;
    logic             pull;

    // A write is only taken when there is room; a full queue drops it.
    assign ready = (count != (QADDR+1)'(DEPTH));
    assign empty = (count == '0);
    assign push  = we && ready;
    assign pull  = pop && !empty;
    assign rdata = mem[rptr];

    // Storage needs no reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally; count tracks push/pop, unchanged on both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pull) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({push, pull})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (we && !ready) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Queued 8N1 UART transmitter: FIFO front end plus a serializer
// whose line output is a flop lagging the state by one cycle.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int SERIAL_WCNT = SERIAL_WCNT_DEF,
    parameter int QADDR       = QADDR_DEF
) (
    input  logic       CLK,
    input  logic       RST_X,
    input  logic [7:0] DATA,
    input  logic       WE,
    output logic       READY,
    output logic       TXD,
    output logic       BUSY,
    output logic       OVF
);

    localparam int CW = $clog2(SERIAL_WCNT);

    tx_state_t     state;
    tx_state_t     state_next;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    head;
    logic          txd_q;
    logic          busy_q;
    logic          pop;
    logic          empty;
    logic          bit_last;

    uart_tx_fifo #(
        .QADDR (QADDR)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_X),
        .wdata (DATA),
        .we    (WE),
        .pop   (pop),
        .rdata (head),
        .ready (READY),
        .empty (empty),
        .ovf   (OVF)
    );

    assign bit_last = (cnt == CW'(SERIAL_WCNT - 1));
    assign TXD      = txd_q;
    assign BUSY     = busy_q | ~empty;

    // Next-state and pop: a byte is pulled when a frame is about to start.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (bit_last) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_last && bit_idx == 3'd7) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_last) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bit timing, shifter and registered line/busy outputs.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            if (state == ST_IDLE || bit_last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (state != ST_DATA) begin
                bit_idx <= '0;
            end else if (bit_last) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (pop) begin
                shreg <= head;
            end else if (state == ST_DATA && bit_last) begin
                shreg <= {1'b0, shreg[7:1]};
            end
            unique case (state)
                ST_START: txd_q <= 1'b0;
                ST_DATA:  txd_q <= shreg[0];
                default:  txd_q <= 1'b1;
            endcase
            busy_q <= (state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: bit-level frame table, a line decoder
// feeding a byte scoreboard, and hand-built queue corner sequences.
module tb_uart_tx_queue;

    localparam int W  = 4;
    localparam int QA = 2;

    logic       CLK;
    logic       RST_X;
    logic [7:0] DATA;
    logic       WE;
    logic       READY;
    logic       TXD;
    logic       BUSY;
    logic       OVF;

    uart_tx_queue #(
        .SERIAL_WCNT (W),
        .QADDR       (QA)
    ) dut (
        .CLK   (CLK),
        .RST_X (RST_X),
        .DATA  (DATA),
        .WE    (WE),
        .READY (READY),
        .TXD   (TXD),
        .BUSY  (BUSY),
        .OVF   (OVF)
    );

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];
    int         mcyc = 0;
    bit         rst_seen = 0;
    vec_t       vecs[3];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge RST_X) rst_seen = 1;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (BUSY !== 1'b0 && n < lim) begin
            @(negedge CLK);
            n++;
        end
        chk("wait_idle", {31'd0, BUSY}, 32'd0);
    endtask

    // Line decoder: samples 1.5 cycles into each bit, checks framing
    // and compares every decoded byte against the scoreboard head.
    initial begin
        bit         prev;
        logic [9:0] f;
        logic [7:0] e;
        prev = 1'b1;
        forever begin
            @(negedge CLK);
            mcyc++;
            if (prev && TXD === 1'b0 && RST_X === 1'b1) begin
                rst_seen = 0;
                start_q.push_back(mcyc);
                @(negedge CLK);
                mcyc++;
                f[0] = TXD;
                for (int i = 1; i < 10; i++) begin
                    repeat (W) begin
                        @(negedge CLK);
                        mcyc++;
                    end
                    f[i] = TXD;
                end
                if (!rst_seen) begin
                    chk("framing", {22'd0, f[9], f[0]}, 32'd2);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", {24'd0, f[8:1]}, 32'hffff);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rx_byte", {24'd0, f[8:1]}, {24'd0, e});
                    end
                end
            end
            prev = TXD;
        end
    end

    initial begin
        int bad;
        vecs[0] = '{8'h55, 10'b1010101010};
        vecs[1] = '{8'hA0, 10'b1101000000};
        vecs[2] = '{8'h01, 10'b1000000010};
        RST_X = 1'b0;
        WE    = 1'b0;
        DATA  = 8'h00;
        repeat (3) @(negedge CLK);
        chk("rst_txd",   {31'd0, TXD},   32'd1);
        chk("rst_ready", {31'd0, READY}, 32'd1);
        chk("rst_busy",  {31'd0, BUSY},  32'd0);
        chk("rst_ovf",   {31'd0, OVF},   32'd0);
        RST_X = 1'b1;
        @(negedge CLK);

        // Single-byte frames, checked cycle by cycle on the line.
        for (int v = 0; v < 3; v++) begin
            DATA = vecs[v].data;
            WE   = 1'b1;
            exp_q.push_back(vecs[v].data);
            @(negedge CLK);
            WE   = 1'b0;
            DATA = 8'($urandom);
            chk("lat_t0", {31'd0, TXD}, 32'd1);
            @(negedge CLK);
            chk("lat_t1", {31'd0, TXD}, 32'd1);
            @(negedge CLK);
            for (int i = 0; i < 10; i++) begin
                for (int j = 0; j < W; j++) begin
                    chk("line_bit", {31'd0, TXD},
                        {31'd0, vecs[v].frame[i]});
                    chk("busy_frame", {31'd0, BUSY}, 32'd1);
                    DATA = 8'($urandom);
                    @(negedge CLK);
                end
            end
            chk("end_busy", {31'd0, BUSY}, 32'd0);
            chk("end_txd",  {31'd0, TXD},  32'd1);
            @(negedge CLK);
        end

        // Three back-to-back frames with no idle gap.
        start_q.delete();
        WE = 1'b1;
        DATA = 8'hA5;
        exp_q.push_back(8'hA5);
        @(negedge CLK);
        DATA = 8'h3C;
        exp_q.push_back(8'h3C);
        @(negedge CLK);
        DATA = 8'hFF;
        exp_q.push_back(8'hFF);
        @(negedge CLK);
        WE = 1'b0;
        wait_idle(1000);
        chk("b2b_frames", start_q.size(), 32'd3);
        for (int i = 1; i < start_q.size(); i++) begin
            chk("b2b_gap", start_q[i] - start_q[i-1], 32'd40);
        end

        // Reset during data bit 3 with two bytes queued.
        WE = 1'b1;
        DATA = 8'h11;
        exp_q.push_back(8'h11);
        @(negedge CLK);
        DATA = 8'h22;
        exp_q.push_back(8'h22);
        @(negedge CLK);
        DATA = 8'h33;
        exp_q.push_back(8'h33);
        @(negedge CLK);
        WE = 1'b0;
        repeat (17) @(negedge CLK);
        chk("pre_rst_txd", {31'd0, TXD}, 32'd0);
        RST_X = 1'b0;
        #1;
        chk("mid_rst_txd",   {31'd0, TXD},   32'd1);
        chk("mid_rst_busy",  {31'd0, BUSY},  32'd0);
        chk("mid_rst_ready", {31'd0, READY}, 32'd1);
        exp_q.delete();
        repeat (2) @(negedge CLK);
        RST_X = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge CLK);
            if (TXD !== 1'b1 || BUSY !== 1'b0) bad++;
        end
        chk("post_rst_quiet", bad, 32'd0);

        // Six writes into an idle queue of four.
        for (int i = 0; i < 6; i++) begin
            if (i == 4) chk("ready_q3", {31'd0, READY}, 32'd1);
            if (i == 5) chk("ready_full", {31'd0, READY}, 32'd0);
            DATA = 8'h10 + 8'(i);
            WE = 1'b1;
            if (i < 5) exp_q.push_back(DATA);
            @(negedge CLK);
        end
        WE = 1'b0;
        chk("ovf_set", {31'd0, OVF}, 32'd1);
        chk("ready_low", {31'd0, READY}, 32'd0);
        wait_idle(2000);
        chk("ovf_sticky", {31'd0, OVF}, 32'd1);

        // Write on the exact pop edge while full, then refill.
        RST_X = 1'b0;
        @(negedge CLK);
        chk("ovf_cleared", {31'd0, OVF}, 32'd0);
        RST_X = 1'b1;
        DATA = 8'h40;
        WE = 1'b1;
        exp_q.push_back(8'h40);
        for (int i = 1; i < 5; i++) begin
            @(negedge CLK);
            DATA = 8'h40 + 8'(i);
            exp_q.push_back(DATA);
        end
        @(negedge CLK);
        WE = 1'b0;
        chk("fill_ready", {31'd0, READY}, 32'd0);
        repeat (36) @(negedge CLK);
        chk("pre_pop_ovf",   {31'd0, OVF},   32'd0);
        chk("pre_pop_ready", {31'd0, READY}, 32'd0);
        DATA = 8'hEE;
        WE = 1'b1;
        @(negedge CLK);
        chk("pop_edge_ovf",   {31'd0, OVF},   32'd1);
        chk("pop_edge_ready", {31'd0, READY}, 32'd1);
        DATA = 8'h77;
        exp_q.push_back(8'h77);
        @(negedge CLK);
        WE = 1'b0;
        chk("refill_ready", {31'd0, READY}, 32'd0);
        wait_idle(2000);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
